window_fetch: RTL and testbench
===============================

Name: window_fetch

Overview:
Parametrised window gather engine for the conv datapath.
- Single-write/single-read synchronous RAM, DEPTH words of DATA_W bits.
- On i_start, latches TAPS read addresses, reads them serially and packs the results into one TAPS*DATA_W output word.
- Adds an output valid/ready handshake, parametrised tap count and widths, and an idle-time quick single-word read.
- Sits between the feature-map writer and the MAC array.

Parameters:
DATA_W, 10, bits per stored element
ADDR_W, 12, RAM address width
DEPTH, 4096, RAM words (must be <= 2**ADDR_W)
TAPS, 9, addresses gathered per window (1..16)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset  in  1  synchronous active-low reset
i_start  in  1  request a window gather; accepted only when o_ready=1
i_addrOut  in  TAPS*ADDR_W  tap addresses; tap k at bits [k*ADDR_W +: ADDR_W]
i_addrIn  in  ADDR_W  write address
i_data  in  DATA_W  write data
i_wrEnable  in  1  write strobe, honoured in every state
i_quickGet  in  1  quick single-word read request (IDLE only)
i_addrOutQuick  in  ADDR_W  quick read address
i_ready  in  1  downstream accepts o_data
o_data  out  TAPS*DATA_W  packed window; tap k at bits [k*DATA_W +: DATA_W]
o_valid  out  1  o_data holds a complete window
o_ready  out  1  block idle and can accept i_start
o_quickData  out  DATA_W  quick read result
o_quickValid  out  1  o_quickData valid this cycle

Behaviour:
- Reset (i_reset=0 at a rising edge): state=IDLE, tap counter=0, o_data=0, o_valid=0, o_quickData=0, o_quickValid=0.
  - o_ready = (state==IDLE) && i_reset, so it is 0 while reset is held.
  - Reset mid-gather aborts; no partial window is ever flagged valid.
  - RAM contents are not cleared.
- RAM:
  - Synchronous read, 1-cycle latency.
  - Read-first on same-address read/write collision: returns old data.
  - Writes with i_addrIn >= DEPTH are ignored.
- States:
  - IDLE -> FETCH on i_start; latch all i_addrOut, set k=0.
  - FETCH:
    - Drive latched tap k to the RAM read port.
    - If k>0, capture RAM output into slot k-1.
    - k==TAPS-1 -> DRAIN, else k++.
  - DRAIN: capture RAM output into slot TAPS-1, then -> HOLD.
  - HOLD:
    - o_valid=1; o_data stable.
    - On i_valid&i_ready (o_valid && i_ready): -> IDLE, o_valid=0 next cycle.
- Latency: start accepted in cycle T -> o_valid=1 in cycle T+TAPS+2 (T+11 for TAPS=9). Minimum window period is TAPS+3 cycles.
- o_data keeps its last window after the handshake until the next gather overwrites it slot by slot.
- Quick read:
  - In IDLE with i_quickGet=1 and i_start=0, i_addrOutQuick is read.
  - o_quickData/o_quickValid are registered; they assert the next cycle for one cycle.
  - i_start and i_quickGet together: start wins, quick request dropped.
  - i_quickGet outside IDLE is ignored; o_quickValid=0.
- i_start outside IDLE is ignored; no queueing.
- Addresses >= DEPTH read as 0.

Optional Feature:
WINDOW_FETCH_ZERO_PAD_EN
- Defined: adds input i_padMask [TAPS-1:0], latched with i_start.
  - Slots with a mask bit set are written 0 at capture time instead of RAM data.
  - RAM is still addressed, so latency is unchanged.
  - Used for image-border padding.
- Undefined: port absent; every slot takes RAM data.

Decomposition:
- Package window_fetch_pkg holds:
  - state enum (IDLE, FETCH, DRAIN, HOLD)
  - default parameter constants
  - tap-slice helper functions (tap address / data offsets)
- One natural sub-module: window_ram, a parametrised simple dual-port synchronous RAM (DATA_W, ADDR_W, DEPTH, read-first).

Test Plan:
- Load RAM[a]=a[9:0] for a=0..4095; start with taps {0,1,2,64,65,66,128,129,130}, i_ready=1 -> o_valid at T+11 for 1 cycle, o_data slots = {0,1,2,64,65,66,128,129,130}.
- Same gather with i_ready=0 for 20 cycles -> o_valid held and o_data stable; i_start pulses during the hold are ignored; i_ready=1 -> IDLE, o_ready=1 next cycle.
- Quick read in IDLE at address 100 -> o_quickValid=1, o_quickData=100 one cycle later; quick read and start together -> no o_quickValid, gather proceeds.
- Deassert i_reset at cycle T+5 of a gather -> o_valid never asserts, o_data=0, o_ready=1 the cycle after reset release.
- Write RAM[65]=0x3FF in the same cycle tap 65 is read -> slot holds the old value 65; the next gather returns 0x3FF.
- With WINDOW_FETCH_ZERO_PAD_EN, i_padMask=9'b100000001 -> slots 0 and 8 are 0, others are RAM data, latency still TAPS+2.

Source files
------------

// File: rtl/window_fetch_pkg.sv
// window_fetch_pkg: shared types, default parameters and tap-slice helpers for the
// window gather engine (window_fetch) and its RAM (window_ram).
// Contents: state_e (gather FSM states), Default* constants, tap_addr_lsb/tap_data_lsb.
package window_fetch_pkg;

    localparam int unsigned DefaultDataW = 10;
    localparam int unsigned DefaultAddrW = 12;
    localparam int unsigned DefaultDepth = 4096;
    localparam int unsigned DefaultTaps  = 9;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StHold
    } state_e;

    // LSB of tap k inside the packed address vector.
    function automatic int unsigned tap_addr_lsb(input int unsigned k, input int unsigned addr_w);
        return k * addr_w;
    endfunction

    // LSB of slot k inside the packed output window.
    function automatic int unsigned tap_data_lsb(input int unsigned k, input int unsigned data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/window_ram.sv
// window_ram: simple dual-port synchronous RAM, one write and one read port, shared clock.
// Read latency is one cycle; a same-address read/write returns the old word (read-first).
// Writes to addresses >= DEPTH are dropped and reads from them return 0.
// Ports:
//   i_clk    clock
//   i_we     write strobe
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  registered read data
module window_ram #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_ok, rd_ok;

    // A RAM that fills its whole address space needs no range check.
    if (DEPTH == (1 << ADDR_W)) begin : g_full
        assign wr_ok = 1'b1;
        assign rd_ok = 1'b1;
    end else begin : g_partial
        assign wr_ok = (i_waddr < ADDR_W'(DEPTH));
        assign rd_ok = (i_raddr < ADDR_W'(DEPTH));
    end

    always_comb begin
        rdata_d = '0;
        if (rd_ok) begin
            rdata_d = mem_q[i_raddr[IDX_W-1:0]];
        end
    end

    // Non-blocking write and read on the same edge give read-first behaviour.
    always_ff @(posedge i_clk) begin
        if (i_we && wr_ok) begin
            mem_q[i_waddr[IDX_W-1:0]] <= i_wdata;
        end
        rdata_q <= rdata_d;
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/window_fetch.sv
// window_fetch: window gather engine between the feature-map writer and the MAC array.
// On an accepted i_start it latches TAPS addresses, reads them one per cycle from window_ram
// and packs the results into o_data, then holds o_valid until downstream takes it.
// While idle, a quick single-word read can be issued instead.
// Optional: define WINDOW_FETCH_ZERO_PAD_EN to add i_padMask (per-slot zero padding).
// Ports:
//   i_clk, i_reset (sync, active-low)
//   i_start, i_addrOut              gather request and packed tap addresses
//   i_addrIn, i_data, i_wrEnable    RAM write port
//   i_quickGet, i_addrOutQuick      idle-time quick read
//   i_ready                         downstream handshake
//   o_data, o_valid, o_ready        packed window, window valid, block idle
//   o_quickData, o_quickValid       quick read result
module window_fetch
    import window_fetch_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned DEPTH  = DefaultDepth,
    parameter int unsigned TAPS   = DefaultTaps
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [TAPS*ADDR_W-1:0] i_addrOut,
    input  logic [ADDR_W-1:0]      i_addrIn,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_wrEnable,
    input  logic                   i_quickGet,
    input  logic [ADDR_W-1:0]      i_addrOutQuick,
    input  logic                   i_ready,
`ifdef WINDOW_FETCH_ZERO_PAD_EN
    input  logic [TAPS-1:0]        i_padMask,
`endif
    output logic [TAPS*DATA_W-1:0] o_data,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic [DATA_W-1:0]      o_quickData,
    output logic                   o_quickValid
);

    localparam int unsigned K_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [K_W-1:0] KLast = K_W'(TAPS - 1);

    state_e                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [TAPS*ADDR_W-1:0]  taps_q, taps_d;
    logic [TAPS*DATA_W-1:0]  data_q, data_d;
    logic [TAPS-1:0]         pad_q, pad_d;
    logic                    valid_q, valid_d;
    logic                    quick_valid_q, quick_valid_d;

    logic [ADDR_W-1:0]       rd_addr;
    logic [DATA_W-1:0]       ram_rdata;
    logic                    capture_en;
    logic [K_W-1:0]          capture_slot;
    logic [DATA_W-1:0]       slot_value;

    window_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (i_wrEnable),
        .i_waddr (i_addrIn),
        .i_wdata (i_data),
        .i_raddr (rd_addr),
        .o_rdata (ram_rdata)
    );

    // Padded slots still consume their read cycle; only the captured value changes.
    assign slot_value = pad_q[capture_slot] ? '0 : ram_rdata;

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        taps_d        = taps_q;
        data_d        = data_q;
        pad_d         = pad_q;
        valid_d       = valid_q;
        quick_valid_d = 1'b0;
        rd_addr       = i_addrOutQuick;
        capture_en    = 1'b0;
        capture_slot  = '0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StFetch;
                    k_d     = '0;
                    taps_d  = i_addrOut;
`ifdef WINDOW_FETCH_ZERO_PAD_EN
                    pad_d   = i_padMask;
`else
                    pad_d   = '0;
`endif
                end else if (i_quickGet) begin
                    quick_valid_d = 1'b1;
                end
            end
            StFetch: begin
                rd_addr = taps_q[tap_addr_lsb(32'(k_q), ADDR_W) +: ADDR_W];
                // RAM output trails the address by one cycle, so slot k-1 lands now.
                if (k_q != '0) begin
                    capture_en   = 1'b1;
                    capture_slot = k_q - K_W'(1);
                end
                if (k_q == KLast) begin
                    state_d = StDrain;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            StDrain: begin
                capture_en   = 1'b1;
                capture_slot = KLast;
                state_d      = StHold;
                valid_d      = 1'b1;
            end
            StHold: begin
                if (i_ready) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (capture_en) begin
            data_d[tap_data_lsb(32'(capture_slot), DATA_W) +: DATA_W] = slot_value;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q       <= StIdle;
            k_q           <= '0;
            taps_q        <= '0;
            data_q        <= '0;
            pad_q         <= '0;
            valid_q       <= 1'b0;
            quick_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            taps_q        <= taps_d;
            data_q        <= data_d;
            pad_q         <= pad_d;
            valid_q       <= valid_d;
            quick_valid_q <= quick_valid_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_ready      = (state_q == StIdle) && i_reset;
    assign o_quickValid = quick_valid_q;
    // The RAM output register already holds the quick word in the cycle after the request.
    assign o_quickData  = quick_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_window_fetch.sv
module tb_window_fetch;
    import window_fetch_pkg::*;

    localparam int unsigned DATA_W = 10;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned TAPS   = 9;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [TAPS*ADDR_W-1:0] addr_out;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;
    logic                   we;
    logic                   quick;
    logic [ADDR_W-1:0]      quick_addr;
    logic                   ready;
    logic [TAPS-1:0]        pad;
    logic [TAPS*DATA_W-1:0] o_data;
    logic                   o_valid, o_ready, o_quickValid;
    logic [DATA_W-1:0]      o_quickData;

    always #5 clk = ~clk;

    window_fetch #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TAPS   (TAPS)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_start        (start),
        .i_addrOut      (addr_out),
        .i_addrIn       (waddr),
        .i_data         (wdata),
        .i_wrEnable     (we),
        .i_quickGet     (quick),
        .i_addrOutQuick (quick_addr),
        .i_ready        (ready),
`ifdef WINDOW_FETCH_ZERO_PAD_EN
        .i_padMask      (pad),
`endif
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_ready        (o_ready),
        .o_quickData    (o_quickData),
        .o_quickValid   (o_quickValid)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a gather accepted at edge E reads tap j at edge E+1+j (value before any
    // write on that edge) and shows it in o_data from edge E+2+j; o_valid from edge E+TAPS+1.
    logic [DATA_W-1:0] m_mem  [DEPTH];
    logic [ADDR_W-1:0] m_taps [TAPS];
    logic [DATA_W-1:0] m_read [TAPS];
    logic [DATA_W-1:0] m_slot [TAPS];
    logic [TAPS-1:0]   m_pad;
    int                m_phase;  // 0 idle, 1 gathering, 2 holding a window
    int                m_cnt;    // edges since the gather was accepted
    logic              m_qv;
    logic [DATA_W-1:0] m_qd;
    bit                chk_en = 1'b0;

    // Sampled at the negedge of the most recent tick.
    logic                   s_valid, s_ready, s_qv;
    logic [DATA_W-1:0]      s_qd;
    logic [TAPS*DATA_W-1:0] s_data;

    function automatic logic [TAPS*DATA_W-1:0] model_window();
        logic [TAPS*DATA_W-1:0] w;
        for (int k = 0; k < TAPS; k++) w[k*DATA_W +: DATA_W] = m_slot[k];
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] slot_of(input logic [TAPS*DATA_W-1:0] w, input int k);
        return w[k*DATA_W +: DATA_W];
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_phase = 0;
            m_cnt   = 0;
            m_qv    = 1'b0;
            m_qd    = '0;
            for (int k = 0; k < TAPS; k++) m_slot[k] = '0;
        end else begin
            m_qv = 1'b0;
            case (m_phase)
                0: begin
                    if (start) begin
                        for (int k = 0; k < TAPS; k++) m_taps[k] = addr_out[k*ADDR_W +: ADDR_W];
`ifdef WINDOW_FETCH_ZERO_PAD_EN
                        m_pad = pad;
`else
                        m_pad = '0;
`endif
                        m_phase = 1;
                        m_cnt   = 0;
                    end else if (quick) begin
                        m_qv = 1'b1;
                        m_qd = m_mem[quick_addr];
                    end
                end
                1: begin
                    m_cnt++;
                    if (m_cnt >= 2) m_slot[m_cnt-2] = m_pad[m_cnt-2] ? '0 : m_read[m_cnt-2];
                    if (m_cnt <= TAPS) m_read[m_cnt-1] = m_mem[m_taps[m_cnt-1]];
                    if (m_cnt == TAPS + 1) m_phase = 2;
                end
                default: begin
                    if (ready) m_phase = 0;
                end
            endcase
        end
        if (we) m_mem[waddr] = wdata;
    endtask

    task automatic tick();
        @(negedge clk);
        s_valid = o_valid;
        s_ready = o_ready;
        s_qv    = o_quickValid;
        s_qd    = o_quickData;
        s_data  = o_data;
        if (chk_en) begin
            check_eq("ready", o_ready, (m_phase == 0) && rst_n);
            check_eq("valid", o_valid, m_phase == 2);
            check_eq("qvalid", o_quickValid, m_qv);
            if (m_qv) check_eq("qdata", o_quickData, m_qd);
            check_eq("data", o_data, model_window());
        end
        @(posedge clk);
        model_edge();
        chk_en = 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        we    = 1'b0;
        quick = 1'b0;
        ready = 1'b1;
        pad   = '0;
    endtask

    task automatic set_std_taps();
        int std_taps [TAPS] = '{0, 1, 2, 64, 65, 66, 128, 129, 130};
        for (int k = 0; k < TAPS; k++) addr_out[k*ADDR_W +: ADDR_W] = ADDR_W'(std_taps[k]);
    endtask

    // Ticks until o_valid is seen; lat = ticks after the start tick, or -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (s_valid) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) check_eq("valid_timeout", 0, 1);
    endtask

    task automatic start_gather();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int                     lat;
    bit                     saw_valid;
    logic [TAPS*DATA_W-1:0] std_win;

    initial begin
        int std_taps [TAPS] = '{0, 1, 2, 64, 65, 66, 128, 129, 130};
        for (int k = 0; k < TAPS; k++) std_win[k*DATA_W +: DATA_W] = DATA_W'(std_taps[k]);

        rst_n      = 1'b0;
        addr_out   = '0;
        waddr      = '0;
        wdata      = '0;
        quick_addr = '0;
        idle_inputs();
        repeat (3) tick();
        check_eq("rst_ready_low", s_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_valid", s_valid, 1'b0);
        check_eq("rst_qvalid", s_qv, 1'b0);
        check_eq("rst_qdata", s_qd, '0);
        check_eq("rst_data", s_data, '0);

        // Load RAM[a] = a[9:0].
        for (int a = 0; a < DEPTH; a++) begin
            we    = 1'b1;
            waddr = ADDR_W'(a);
            wdata = DATA_W'(a);
            tick();
        end
        idle_inputs();

        // Basic gather, downstream always ready.
        set_std_taps();
        start_gather();
        wait_valid(lat);
        check_eq("latency", lat, TAPS + 2);
        check_eq("window", s_data, std_win);
        tick();
        check_eq("valid_one_cycle", s_valid, 1'b0);

        // Back-pressure: hold for 20 cycles with ignored start pulses.
        ready = 1'b0;
        start_gather();
        wait_valid(lat);
        for (int n = 0; n < 20; n++) begin
            start = n[0];
            tick();
            check_eq("hold_valid", s_valid, 1'b1);
            check_eq("hold_data", s_data, std_win);
        end
        start = 1'b0;
        ready = 1'b1;
        tick();
        tick();
        check_eq("ready_after_hs", s_ready, 1'b1);

        // Quick read, then quick+start together.
        quick      = 1'b1;
        quick_addr = ADDR_W'(100);
        tick();
        quick = 1'b0;
        tick();
        check_eq("quick_valid", s_qv, 1'b1);
        check_eq("quick_data", s_qd, DATA_W'(100));
        quick = 1'b1;
        start = 1'b1;
        tick();
        quick = 1'b0;
        start = 1'b0;
        tick();
        check_eq("quick_dropped", s_qv, 1'b0);
        check_eq("start_won", s_ready, 1'b0);
        wait_valid(lat);
        check_eq("latency_after_quick", lat, TAPS + 1);
        tick();

        // Reset in cycle T+5 of a gather.
        start_gather();
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("ready_after_abort", s_ready, 1'b1);
        check_eq("data_after_abort", s_data, '0);
        saw_valid = 1'b0;
        repeat (20) begin
            tick();
            if (s_valid) saw_valid = 1'b1;
        end
        check_eq("no_partial_valid", saw_valid, 1'b0);

        // Write RAM[65] on the edge that reads tap 4 (address 65).
        start_gather();
        repeat (4) tick();
        we    = 1'b1;
        waddr = ADDR_W'(65);
        wdata = 10'h3FF;
        tick();
        we = 1'b0;
        wait_valid(lat);
        check_eq("collide_old", slot_of(s_data, 4), DATA_W'(65));
        tick();
        start_gather();
        wait_valid(lat);
        check_eq("collide_new", slot_of(s_data, 4), 10'h3FF);
        tick();

`ifdef WINDOW_FETCH_ZERO_PAD_EN
        pad = 9'b100000001;
        start_gather();
        pad = '0;
        wait_valid(lat);
        check_eq("pad_latency", lat, TAPS + 2);
        check_eq("pad_slot0", slot_of(s_data, 0), '0);
        check_eq("pad_slot8", slot_of(s_data, 8), '0);
        check_eq("pad_slot1", slot_of(s_data, 1), DATA_W'(1));
        tick();
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 3) == 0);
            quick = ($urandom_range(0, 2) == 0);
            ready = ($urandom_range(0, 1) == 0);
            we    = ($urandom_range(0, 1) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            pad   = TAPS'($urandom);
            waddr = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(0, DEPTH - 1))
                                                : ADDR_W'($urandom_range(0, 31));
            wdata = DATA_W'($urandom);
            quick_addr = ADDR_W'($urandom_range(0, 31));
            for (int k = 0; k < TAPS; k++) begin
                addr_out[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 3) == 0)
                    ? ADDR_W'($urandom_range(0, DEPTH - 1)) : ADDR_W'($urandom_range(0, 31));
            end
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
